// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one line-wide memory port among NCH cache-side ports,
//            one line transaction in flight, round-robin or fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int NCH     = 2,
  parameter int ADDR_W  = 28,
  parameter int LINE_W  = 128,
  parameter int RR_MODE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH-1:0]          ch_read,
  input  logic [NCH-1:0]          ch_write,
  input  logic [NCH*ADDR_W-1:0]   ch_addr,
  input  logic [NCH*LINE_W-1:0]   ch_wdata,
  output logic [LINE_W-1:0]       ch_rdata,
  output logic [NCH-1:0]          ch_ready,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LINE_W-1:0]       mem_wdata,
  input  logic [LINE_W-1:0]       mem_rdata,
  input  logic                    mem_ready,
  output logic [$clog2(NCH)-1:0]  grant_id,
  output logic                    busy
);

  localparam int CW = $clog2(NCH);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_BUSY = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CW-1:0]     r_rr_ptr;
  logic [CW-1:0]     w_rr_ptr_nxt;
  logic [NCH-1:0]    w_req;
  logic              w_found;
  logic [CW-1:0]     w_win;

  logic [ADDR_W-1:0] w_sel_addr;
  logic [LINE_W-1:0] w_sel_wdata;
  logic              w_sel_wr;

  logic [CW-1:0]     w_grant_nxt;
  logic              w_mem_read_nxt;
  logic              w_mem_write_nxt;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [LINE_W-1:0] w_mem_wdata_nxt;
  logic [LINE_W-1:0] w_ch_rdata_nxt;
  logic [NCH-1:0]    w_ch_ready_nxt;
  logic              w_busy_nxt;

  assign w_req   = ch_read | ch_write;
  assign w_found = |w_req;

  generate
    if (RR_MODE != 0) begin : g_rr
      logic [CW:0] w_idx;
      // Walk downward so the last hit is the first requester at or after rr_ptr.
      always_comb begin
        w_win = '0;
        w_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
          w_idx = {1'b0, r_rr_ptr} + (CW+1)'(k);
          if (w_idx >= (CW+1)'(NCH)) w_idx = w_idx - (CW+1)'(NCH);
          if (w_req[w_idx[CW-1:0]]) w_win = w_idx[CW-1:0];
        end
      end
    end else begin : g_fixed
      always_comb begin
        w_win = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
          if (w_req[k]) w_win = CW'(k);
        end
      end
    end
  endgenerate

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wr    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (w_win == CW'(i)) begin
        w_sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = ch_wdata[i*LINE_W +: LINE_W];
        w_sel_wr    = ch_write[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_found) w_state_nxt = c_ST_BUSY;
      c_ST_BUSY: if (mem_ready) w_state_nxt = c_ST_DONE;
      c_ST_DONE: w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Next values for the registered outputs; the output registers double as the request latch.
  always_comb begin
    w_grant_nxt     = grant_id;
    w_mem_read_nxt  = mem_read;
    w_mem_write_nxt = mem_write;
    w_mem_addr_nxt  = mem_addr;
    w_mem_wdata_nxt = mem_wdata;
    w_ch_rdata_nxt  = ch_rdata;
    w_ch_ready_nxt  = '0;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_busy_nxt      = (w_state_nxt != c_ST_IDLE);
    case (r_state)
      c_ST_IDLE: begin
        if (w_found) begin
          w_grant_nxt     = w_win;
          w_mem_addr_nxt  = w_sel_addr;
          w_mem_wdata_nxt = w_sel_wdata;
          w_mem_write_nxt = w_sel_wr;
          w_mem_read_nxt  = ~w_sel_wr;
        end
      end
      c_ST_BUSY: begin
        if (mem_ready) begin
          w_mem_read_nxt  = 1'b0;
          w_mem_write_nxt = 1'b0;
          w_ch_rdata_nxt  = mem_rdata;
          for (int i = 0; i < NCH; i++) begin
            w_ch_ready_nxt[i] = (grant_id == CW'(i));
          end
        end
      end
      c_ST_DONE: begin
        w_rr_ptr_nxt = (grant_id == CW'(NCH - 1)) ? '0 : grant_id + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_id  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ch_rdata  <= '0;
      ch_ready  <= '0;
      busy      <= 1'b0;
      r_rr_ptr  <= '0;
    end else begin
      grant_id  <= w_grant_nxt;
      mem_read  <= w_mem_read_nxt;
      mem_write <= w_mem_write_nxt;
      mem_addr  <= w_mem_addr_nxt;
      mem_wdata <= w_mem_wdata_nxt;
      ch_rdata  <= w_ch_rdata_nxt;
      ch_ready  <= w_ch_ready_nxt;
      busy      <= w_busy_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed scoreboard bench: 2-channel round-robin and 4-channel
//            fixed-priority arbiters against behavioural line memories.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 28;
  localparam int LW = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lat    = 5;

  typedef struct {
    int              ch;
    bit              rd;
    logic [LW-1:0]   data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  function automatic logic [LW-1:0] line_of(logic [AW-1:0] a);
    return {4{a, 4'h5}};
  endfunction

  task automatic chk(string tag, logic [LW-1:0] obs, logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- instance A: NCH=2, round-robin ----------------
  int              a_iss [2];
  int              a_don [2];
  logic [1:0]      a_ord = '0;
  logic [1:0]      a_owr = '0;
  logic [1:0]      a_read, a_write, a_ready;
  logic [2*AW-1:0] a_addr  = '0;
  logic [2*LW-1:0] a_wdata = '0;
  logic [LW-1:0]   a_rdata, a_mwdata;
  logic [LW-1:0]   a_mrdata = '0;
  logic            a_mrd, a_mwr, a_gid, a_busy;
  logic            a_mready = 1'b0;
  logic [AW-1:0]   a_maddr;

  for (genvar i = 0; i < 2; i++) begin : g_a_req
    assign a_read[i]  = (a_iss[i] != a_don[i]) && a_ord[i];
    assign a_write[i] = (a_iss[i] != a_don[i]) && a_owr[i];
  end

  mem_port_arbiter #(.NCH(2), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .ch_read(a_read), .ch_write(a_write), .ch_addr(a_addr), .ch_wdata(a_wdata),
    .ch_rdata(a_rdata), .ch_ready(a_ready),
    .mem_read(a_mrd), .mem_write(a_mwr), .mem_addr(a_maddr), .mem_wdata(a_mwdata),
    .mem_rdata(a_mrdata), .mem_ready(a_mready),
    .grant_id(a_gid), .busy(a_busy)
  );

  // ---------------- instance B: NCH=4, fixed priority ----------------
  int              b_iss [4];
  int              b_don [4];
  logic [3:0]      b_ord = '0;
  logic [3:0]      b_owr = '0;
  logic [3:0]      b_read, b_write, b_ready;
  logic [4*AW-1:0] b_addr  = '0;
  logic [4*LW-1:0] b_wdata = '0;
  logic [LW-1:0]   b_rdata, b_mwdata;
  logic [LW-1:0]   b_mrdata = '0;
  logic            b_mrd, b_mwr, b_busy, b_mready;
  logic            b_mrdy_m = 1'b0;
  logic            b_spur   = 1'b0;
  logic [1:0]      b_gid;
  logic [AW-1:0]   b_maddr;

  assign b_mready = b_mrdy_m | b_spur;

  for (genvar i = 0; i < 4; i++) begin : g_b_req
    assign b_read[i]  = (b_iss[i] != b_don[i]) && b_ord[i];
    assign b_write[i] = (b_iss[i] != b_don[i]) && b_owr[i];
  end

  mem_port_arbiter #(.NCH(4), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .ch_read(b_read), .ch_write(b_write), .ch_addr(b_addr), .ch_wdata(b_wdata),
    .ch_rdata(b_rdata), .ch_ready(b_ready),
    .mem_read(b_mrd), .mem_write(b_mwr), .mem_addr(b_maddr), .mem_wdata(b_mwdata),
    .mem_rdata(b_mrdata), .mem_ready(b_mready),
    .grant_id(b_gid), .busy(b_busy)
  );

  // ---------------- behavioural memories ----------------
  logic [LW-1:0] mem_a [256];
  logic [LW-1:0] mem_b [256];
  logic [255:0]  vld_a = '0;
  logic [255:0]  vld_b = '0;
  int            a_cnt = 0;
  int            b_cnt = 0;

  always @(posedge clk) begin
    if (!rst_n || a_mready) begin
      a_mready <= 1'b0;
      a_cnt    <= 0;
    end else if (a_mrd || a_mwr) begin
      if (a_cnt >= lat - 1) begin
        a_mready <= 1'b1;
        a_cnt    <= 0;
        a_mrdata <= vld_a[a_maddr[7:0]] ? mem_a[a_maddr[7:0]] : line_of(a_maddr);
        if (a_mwr) begin
          mem_a[a_maddr[7:0]] <= a_mwdata;
          vld_a[a_maddr[7:0]] <= 1'b1;
        end
      end else a_cnt <= a_cnt + 1;
    end else a_cnt <= 0;
  end

  always @(posedge clk) begin
    if (!rst_n || b_mrdy_m) begin
      b_mrdy_m <= 1'b0;
      b_cnt    <= 0;
    end else if (b_mrd || b_mwr) begin
      if (b_cnt >= lat - 1) begin
        b_mrdy_m <= 1'b1;
        b_cnt    <= 0;
        b_mrdata <= vld_b[b_maddr[7:0]] ? mem_b[b_maddr[7:0]] : line_of(b_maddr);
        if (b_mwr) begin
          mem_b[b_maddr[7:0]] <= b_mwdata;
          vld_b[b_maddr[7:0]] <= 1'b1;
        end
      end else b_cnt <= b_cnt + 1;
    end else b_cnt <= 0;
  end

  // ---------------- completion monitors / scoreboards ----------------
  logic [1:0] a_prev = '0;
  logic [3:0] b_prev = '0;

  always @(negedge clk) begin : p_mon_a
    exp_t e;
    if (rst_n) begin
      if (a_busy && a_ready == '0) chk("A_req_held", a_read[a_gid] | a_write[a_gid], 1);
      if (a_ready != '0) begin
        chk("A_onehot", $onehot(a_ready), 1);
        chk("A_pulse_len", a_prev, 0);
        if (qa.size() == 0) chk("A_unexpected_ready", a_ready, 0);
        else begin
          e = qa.pop_front();
          chk("A_ready_ch", a_ready, 2'b01 << e.ch);
          chk("A_grant_id", a_gid, e.ch);
          if (e.rd) chk("A_rdata", a_rdata, e.data);
        end
        for (int i = 0; i < 2; i++) if (a_ready[i]) a_don[i] <= a_don[i] + 1;
      end
      a_prev <= a_ready;
    end else a_prev <= '0;
  end

  always @(negedge clk) begin : p_mon_b
    exp_t e;
    if (rst_n) begin
      if (b_busy && b_ready == '0) chk("B_req_held", b_read[b_gid] | b_write[b_gid], 1);
      if (b_ready != '0) begin
        chk("B_onehot", $onehot(b_ready), 1);
        chk("B_pulse_len", b_prev, 0);
        if (qb.size() == 0) chk("B_unexpected_ready", b_ready, 0);
        else begin
          e = qb.pop_front();
          chk("B_ready_ch", b_ready, 4'b0001 << e.ch);
          chk("B_grant_id", b_gid, e.ch);
          if (e.rd) chk("B_rdata", b_rdata, e.data);
        end
        for (int i = 0; i < 4; i++) if (b_ready[i]) b_don[i] <= b_don[i] + 1;
      end
      b_prev <= b_ready;
    end else b_prev <= '0;
  end

  // ---------------- stimulus helpers ----------------
  task automatic req_a(int ch, bit rd, bit wr, logic [AW-1:0] addr, logic [LW-1:0] wd);
    a_addr[ch*AW +: AW]  = addr;
    a_wdata[ch*LW +: LW] = wd;
    a_ord[ch]            = rd;
    a_owr[ch]            = wr;
    a_iss[ch]++;
  endtask

  task automatic req_b(int ch, bit rd, bit wr, logic [AW-1:0] addr, logic [LW-1:0] wd);
    b_addr[ch*AW +: AW]  = addr;
    b_wdata[ch*LW +: LW] = wd;
    b_ord[ch]            = rd;
    b_owr[ch]            = wr;
    b_iss[ch]++;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((qa.size() != 0 || qb.size() != 0 || a_busy || b_busy) && n < budget);
    chk("idle_pending", qa.size() + qb.size(), 0);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_a_rdata"},  a_rdata,  0);
    chk({tag, "_a_ready"},  a_ready,  0);
    chk({tag, "_a_mrd"},    a_mrd,    0);
    chk({tag, "_a_mwr"},    a_mwr,    0);
    chk({tag, "_a_maddr"},  a_maddr,  0);
    chk({tag, "_a_mwdata"}, a_mwdata, 0);
    chk({tag, "_a_gid"},    a_gid,    0);
    chk({tag, "_a_busy"},   a_busy,   0);
    chk({tag, "_b_ready"},  b_ready,  0);
    chk({tag, "_b_busy"},   b_busy,   0);
  endtask

  localparam logic [LW-1:0] c_WD_A5   = {16{8'hA5}};
  localparam logic [LW-1:0] c_WD_BEEF = {8{16'hBEEF}};

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_zero("rst0");
    rst_n = 1'b1;

    // Reset mid-BUSY: first move rr_ptr to 1, then abandon a ch1 read.
    qa.push_back('{0, 1'b1, line_of(28'h0000040)});
    req_a(0, 1'b1, 1'b0, 28'h0000040, '0);
    wait_idle(100);
    lat = 12;
    req_a(1, 1'b1, 1'b0, 28'h0000080, '0);
    @(negedge clk);
    chk("rst_pre_mem_read", a_mrd, 1);
    @(negedge clk);
    rst_n     = 1'b0;
    a_iss[1]  = a_don[1];
    repeat (2) @(negedge clk);
    check_zero("rst_mid");
    rst_n = 1'b1;
    lat   = 5;
    qa.push_back('{0, 1'b1, line_of(28'h0000041)});
    qa.push_back('{1, 1'b1, line_of(28'h0000081)});
    req_a(0, 1'b1, 1'b0, 28'h0000041, '0);
    req_a(1, 1'b1, 1'b0, 28'h0000081, '0);
    wait_idle(200);

    // Single read on ch1, latency 5.
    qa.push_back('{1, 1'b1, line_of(28'h0000123)});
    req_a(1, 1'b1, 1'b0, 28'h0000123, '0);
    @(negedge clk);
    chk("T2_mem_read", a_mrd, 1);
    chk("T2_mem_write", a_mwr, 0);
    chk("T2_mem_addr", a_maddr, 28'h0000123);
    chk("T2_busy", a_busy, 1);
    n = 0;
    while (!a_mready && n < 50) begin
      @(negedge clk);
      chk("T2_no_early_ready", a_ready, 0);
      n++;
    end
    chk("T2_mready_seen", a_mready, 1);
    @(negedge clk);
    chk("T2_ch_ready", a_ready, 2'b10);
    chk("T2_strobe_low", a_mrd, 0);
    chk("T2_rdata", a_rdata, line_of(28'h0000123));
    wait_idle(100);

    // Round-robin contention: both channels request twice.
    qa.push_back('{0, 1'b1, line_of(28'h0000200)});
    qa.push_back('{1, 1'b1, line_of(28'h0000301)});
    qa.push_back('{0, 1'b1, line_of(28'h0000200)});
    qa.push_back('{1, 1'b1, line_of(28'h0000301)});
    req_a(0, 1'b1, 1'b0, 28'h0000200, '0);
    req_a(1, 1'b1, 1'b0, 28'h0000301, '0);
    req_a(0, 1'b1, 1'b0, 28'h0000200, '0);
    req_a(1, 1'b1, 1'b0, 28'h0000301, '0);
    wait_idle(300);

    // Write then read on ch0; addr/wdata changes after grant must be ignored.
    qa.push_back('{0, 1'b0, '0});
    req_a(0, 1'b0, 1'b1, 28'h0ABCDEF, c_WD_A5);
    @(negedge clk);
    chk("T5_mem_write", a_mwr, 1);
    chk("T5_mem_read", a_mrd, 0);
    chk("T5_mem_wdata", a_mwdata, c_WD_A5);
    a_addr[0 +: AW]  = 28'h0FFFFFF;
    a_wdata[0 +: LW] = '1;
    @(negedge clk);
    chk("T5_addr_latched", a_maddr, 28'h0ABCDEF);
    chk("T5_wdata_latched", a_mwdata, c_WD_A5);
    wait_idle(100);
    qa.push_back('{0, 1'b1, c_WD_A5});
    req_a(0, 1'b1, 1'b0, 28'h0ABCDEF, '0);
    wait_idle(100);

    // Fixed priority, 4 channels, two requests each: lowest index drains first.
    for (int c = 0; c < 4; c++) begin
      qb.push_back('{c, 1'b1, line_of(28'h0000100 + 28'(c))});
      qb.push_back('{c, 1'b1, line_of(28'h0000100 + 28'(c))});
      req_b(c, 1'b1, 1'b0, 28'h0000100 + 28'(c), '0);
      req_b(c, 1'b1, 1'b0, 28'h0000100 + 28'(c), '0);
    end
    wait_idle(600);

    // ch2 asserts read and write together: the write must win.
    qb.push_back('{2, 1'b0, '0});
    req_b(2, 1'b1, 1'b1, 28'h0000777, c_WD_BEEF);
    @(negedge clk);
    chk("T6_mem_write", b_mwr, 1);
    chk("T6_mem_read", b_mrd, 0);
    chk("T6_grant", b_gid, 2);
    n = 0;
    while (b_ready == '0 && n < 50) begin
      @(negedge clk);
      chk("T6_no_mem_read", b_mrd, 0);
      n++;
    end
    chk("T6_ready_seen", |b_ready, 1);
    wait_idle(100);

    // Spurious mem_ready while idle.
    b_spur = 1'b1;
    @(negedge clk);
    b_spur = 1'b0;
    @(negedge clk);
    chk("T6_spur_ready", b_ready, 0);
    chk("T6_spur_busy", b_busy, 0);
    @(negedge clk);
    chk("T6_spur_ready2", b_ready, 0);

    // Read back the line written by ch2 through ch1.
    qb.push_back('{1, 1'b1, c_WD_BEEF});
    req_b(1, 1'b1, 1'b0, 28'h0000777, '0);
    wait_idle(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
